// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of the single fifo_top write port
// among NREQ requesters in the write clock domain. A grant lasts for up to
// MAX_BURST accepted words, until the requester flags its last word, or until
// it withdraws its request. winc/wdata are driven combinationally from the
// granted requester so that wfull back-pressure acts in the same cycle.
module fifo_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    ack,
  output logic               winc,
  output logic [DW-1:0]      wdata,
  input  logic               wfull,
  output logic [2:0]         grant_id,
  output logic               busy
);

  // Index width for requesters and beat counter width (holds MAX_BURST-1).
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [GW-1:0] REQ_LAST_IDX = GW'(NREQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [DW-1:0]   data_arr [NREQ];
  logic            gnt_req;
  logic            gnt_last;
  logic            accept;
  logic [GW-1:0]   gnt_next_ptr;
  logic [GW-1:0]   pick;

  // First requesting index found when searching upward from ptr, modulo NREQ.
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [GW-1:0]   ptr);
    logic [GW-1:0] sel;
    logic [GW-1:0] cand;
    logic          found;
    int            sum;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      cand = GW'(sum);
      if (!found && r[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Split the flat requester data bus into per-requester words.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      data_arr[k] = req_data[k*DW +: DW];
    end
  end

  // Granted requester view and the round-robin pointer that follows it.
  always_comb begin
    gnt_req      = req[gnt_q];
    gnt_last     = req_last[gnt_q];
    gnt_next_ptr = (gnt_q == REQ_LAST_IDX) ? '0 : gnt_q + GW'(1);
    pick         = rr_pick(req, rr_ptr_q);
  end

  // Write-port outputs: a word passes only while granted and the FIFO has room.
  always_comb begin
    accept   = (state_q == GRANT) && gnt_req && !wfull;
    winc     = accept;
    ack      = '0;
    wdata    = '0;
    if (accept) begin
      ack[gnt_q] = 1'b1;
      wdata      = data_arr[gnt_q];
    end
    busy     = (state_q == GRANT);
    grant_id = 3'(gnt_q);
  end

  // Next-state logic: arbitrate in IDLE, count beats and detect burst end in GRANT.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d      = pick;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!gnt_req) begin
          // Requester withdrew: release the port without a write.
          state_d    = IDLE;
          rr_ptr_d   = gnt_next_ptr;
          beat_cnt_d = '0;
        end else if (accept) begin
          if (gnt_last || (beat_cnt_q == BEAT_LAST)) begin
            state_d    = IDLE;
            rr_ptr_d   = gnt_next_ptr;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
        // Otherwise wfull is stalling the burst: hold everything.
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous reset so winc/ack drop as soon as reset asserts.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: requester models feed queued words,
// expected writes go into a scoreboard queue, and a negedge monitor pops and
// compares every write the arbiter performs.
module tb_fifo_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic              wclk = 1'b0;
  logic              wrst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   ack;
  logic              winc;
  logic [DW-1:0]     wdata;
  logic              wfull;
  logic [2:0]        grant_id;
  logic              busy;

  fifo_write_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
    .req_last(req_last), .ack(ack), .winc(winc), .wdata(wdata),
    .wfull(wfull), .grant_id(grant_id), .busy(busy)
  );

  always #5 wclk = ~wclk;

  typedef struct packed { logic last; logic [DW-1:0] data; } word_t;
  typedef struct packed { logic [2:0] id; logic [DW-1:0] data; } exp_t;

  word_t       wq [NREQ][$];
  exp_t        exp_q [$];
  logic [NREQ-1:0] ack_seen = '0;

  bit          trace_on = 1'b0;
  bit          t_winc [$];
  bit          t_ack [$];
  bit          t_busy [$];
  logic [2:0]  t_gid [$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, act, req_v);
    end
  endtask

  // Monitor: records per-cycle trace and checks every write against the scoreboard.
  always @(negedge wclk) begin
    exp_t e;
    ack_seen = ack;
    if (trace_on) begin
      t_winc.push_back(winc);
      t_ack.push_back(|ack);
      t_busy.push_back(busy);
      t_gid.push_back(grant_id);
    end
    if (winc === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_write got wdata=%0h required no write", wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wdata", wdata, e.data);
        chk("ack_onehot", ack, 64'(1) << e.id);
        chk("write_grant_id", grant_id, e.id);
      end
    end
  end

  // Requester models: retire the acked word, then present the next queued word.
  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      if (ack_seen[k] && wq[k].size() > 0) void'(wq[k].pop_front());
      if (wq[k].size() > 0) begin
        req[k] = 1'b1;
        req_data[k*DW +: DW] = wq[k][0].data;
        req_last[k] = wq[k][0].last;
      end else begin
        req[k] = 1'b0;
        req_data[k*DW +: DW] = '0;
        req_last[k] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
    drive();
  endtask

  task automatic load(int k, logic [DW-1:0] d, logic last);
    wq[k].push_back({last, d});
  endtask

  task automatic expect_wr(int k, logic [DW-1:0] d);
    exp_q.push_back({3'(k), d});
  endtask

  task automatic clear_trace();
    t_winc.delete(); t_ack.delete(); t_busy.delete(); t_gid.delete();
  endtask

  task automatic check_trace(string name, string pat);
    chk({name, "_len"}, t_winc.size(), pat.len());
    for (int i = 0; i < pat.len() && i < t_winc.size(); i++) begin
      chk($sformatf("%s_winc[%0d]", name, i), t_winc[i], pat.substr(i, i) == "1");
      chk($sformatf("%s_ack[%0d]", name, i), t_ack[i], pat.substr(i, i) == "1");
    end
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    wfull  = 1'b0;
    for (int k = 0; k < NREQ; k++) wq[k].delete();
    drive();
    @(posedge wclk);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    wrst_n = 1'b0; wfull = 1'b0; req = '0; req_data = '0; req_last = '0;
    #1;
    chk("rst_winc", winc, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_wdata", wdata, 0);
    do_reset();

    // Idle with no requests for 20 cycles.
    trace_on = 1'b1;
    repeat (20) tick();
    trace_on = 1'b0;
    check_trace("idle", "00000000000000000000");
    for (int i = 0; i < t_busy.size(); i++) begin
      chk($sformatf("idle_busy[%0d]", i), t_busy[i], 0);
      chk($sformatf("idle_gid[%0d]", i), t_gid[i], 0);
    end
    clear_trace();

    // Single requester 2: 6 words, last on 0xA5; burst split 4 + 2 with a bubble.
    for (int i = 0; i < 6; i++) begin
      load(2, 32'hA0 + i, i == 5);
      expect_wr(2, 32'hA0 + i);
    end
    tick();
    trace_on = 1'b1;
    repeat (9) tick();
    trace_on = 1'b0;
    check_trace("single", "011110110");
    for (int i = 1; i < t_gid.size(); i++) chk($sformatf("single_gid[%0d]", i), t_gid[i], 2);
    chk("single_drain", exp_q.size(), 0);
    clear_trace();

    // Round robin: all four request, 2-word bursts; order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 4; i++) load(0, 32'hC0 + i, (i % 2) == 1);
    for (int k = 1; k < NREQ; k++) for (int i = 0; i < 2; i++) load(k, 32'hD0 + 32'h10 * k + i, i == 1);
    expect_wr(0, 32'hC0); expect_wr(0, 32'hC1);
    expect_wr(1, 32'hE0); expect_wr(1, 32'hE1);
    expect_wr(2, 32'hF0); expect_wr(2, 32'hF1);
    expect_wr(3, 32'h100); expect_wr(3, 32'h101);
    expect_wr(0, 32'hC2); expect_wr(0, 32'hC3);
    tick();
    trace_on = 1'b1;
    repeat (16) tick();
    trace_on = 1'b0;
    check_trace("rr", "0110110110110110");
    chk("rr_drain", exp_q.size(), 0);
    clear_trace();

    // Back-pressure on requester 1: wfull high for 3 cycles after the 2nd word.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(1, 32'hB0 + i, i == 3);
      expect_wr(1, 32'hB0 + i);
    end
    tick();
    trace_on = 1'b1;
    tick(); tick(); tick();
    wfull = 1'b1;
    tick(); tick(); tick();
    wfull = 1'b0;
    tick(); tick(); tick();
    trace_on = 1'b0;
    check_trace("bp", "011000110");
    chk("bp_drain", exp_q.size(), 0);
    clear_trace();

    // Withdrawal: requester 3 sends one word then drops req; requester 0 goes next.
    load(3, 32'h3300, 1'b0);
    load(0, 32'h0300, 1'b1);
    expect_wr(3, 32'h3300);
    expect_wr(0, 32'h0300);
    tick();
    trace_on = 1'b1;
    repeat (6) tick();
    trace_on = 1'b0;
    check_trace("wd", "010010");
    chk("wd_gid_hold", t_gid[2], 3);
    chk("wd_busy_hold", t_busy[2], 1);
    chk("wd_busy_exit", t_busy[3], 0);
    chk("wd_drain", exp_q.size(), 0);
    clear_trace();

    // Two requesters, 16 words each, with intermittent wfull; 4-word bursts alternate.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      load(0, 32'h1000 + i, 1'b0);
      load(1, 32'h2000 + i, 1'b0);
    end
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) expect_wr(0, 32'h1000 + 4 * b + i);
      for (int i = 0; i < 4; i++) expect_wr(1, 32'h2000 + 4 * b + i);
    end
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      tick();
      wfull = ((c % 5) == 3);
    end
    wfull = 1'b0;
    tick();
    chk("e2e_drain", exp_q.size(), 0);

    // Async reset mid-burst: outputs drop before the next edge.
    do_reset();
    for (int i = 0; i < 4; i++) load(2, 32'h5500 + i, 1'b0);
    tick();
    tick();
    #1;
    chk("ar_winc_before", winc, 1);
    chk("ar_wdata_before", wdata, 32'h5500);
    wrst_n = 1'b0;
    #1;
    chk("ar_winc", winc, 0);
    chk("ar_ack", ack, 0);
    chk("ar_busy", busy, 0);
    for (int k = 0; k < NREQ; k++) wq[k].delete();
    drive();
    @(posedge wclk);
    #2;
    wrst_n = 1'b1;
    tick();
    tick();
    #1;
    chk("ar_gid_after", grant_id, 0);
    chk("ar_busy_after", busy, 0);
    chk("ar_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of fifo_top (winc/wdata/wfull) among NREQ requesters in the write clock domain.
- Round-robin grant; a grant holds for a burst of up to MAX_BURST words, or until the requester marks its last word.
- Drives winc/wdata combinationally from the granted requester, so the FIFO's wfull back-pressure takes effect in the same cycle.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, data width; must match fifo_top wdata
MAX_BURST, 4, maximum words accepted per grant (1..16)

Ports:
wclk  input  1  write-domain clock, rising edge
wrst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester word valid
req_data  input  NREQ*DW  requester k data in bits [k*DW +: DW]
req_last  input  NREQ  marks the current word as the final word of a burst
ack  output  NREQ  one-hot; word from the granted requester accepted this cycle
winc  output  1  FIFO write enable, to fifo_top winc
wdata  output  DW  FIFO write data, to fifo_top wdata
wfull  input  1  FIFO full, from fifo_top
grant_id  output  3  index of the current or most recent grant
busy  output  1  1 while in GRANT state

Behaviour:
- Reset (wrst_n=0, asynchronous): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0, ack=0, winc=0, wdata=0.
- States are IDLE and GRANT; transitions occur on the rising edge of wclk.
- IDLE:
  - If req != 0, select the first k with req[k]=1, searching k = rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Register grant_id=k, beat_cnt=0, go to GRANT.
  - No write occurs in IDLE; this costs a one-cycle arbitration bubble.
- GRANT, with g = grant_id, all combinational:
  - accept = req[g] & ~wfull.
  - winc = accept; ack[g] = accept; all other ack bits = 0.
  - wdata = req_data[g] when accept, else 0.
- GRANT, on each accept: beat_cnt increments.
- GRANT exits to IDLE with rr_ptr=(g+1) mod NREQ when any of these holds:
  - (a) accept & req_last[g];
  - (b) accept & beat_cnt==MAX_BURST-1;
  - (c) req[g]=0 (requester withdrew; no write that cycle).
- GRANT with req[g]=1 & wfull=1: hold state; winc=0; ack=0; beat_cnt unchanged. There is no timeout.
- Latency: req[k] rises in cycle N with the arbiter idle and no other request → ack[k]/winc in cycle N+1 if wfull=0.
- Fairness: a requester that is continuously requesting waits at most (NREQ-1) grants.
- A requester seeing ack[k]=1 must present its next word (or drop req) in the following cycle.
- Requests from non-granted requesters are ignored until the next IDLE.
- wfull asserting mid-burst stalls the burst; no words are lost or duplicated.
- wfull and req_last in the same cycle: no accept, so the burst does not end.
- MAX_BURST=1: every grant is exactly one word, giving strict word-level round robin.
- rr_ptr wraps from NREQ-1 to 0.
- grant_id bits above clog2(NREQ) read 0.
- Reset asserted mid-burst: winc and ack drop immediately (asynchronously). The partially written burst is the requester's responsibility.
- Width rule: beat_cnt is wide enough to hold MAX_BURST-1; no overflow is possible.

Test Plan:
- Reset then idle: req=0 for 20 cycles → winc=0, ack=0, busy=0, grant_id=0 throughout.
- Single requester: req[2]=1 with data 0xA0..0xA5, req_last on 0xA5, MAX_BURST=4:
  - winc accepts 0xA0..0xA3, then a one-cycle bubble in IDLE, then 0xA4, 0xA5.
  - grant_id=2 throughout; 6 acks total.
- Round robin: req=4'b1111 held, each requester sending 2-word bursts with req_last on word 2:
  - grant order 0,1,2,3,0.
  - Each burst is 2 writes followed by one idle cycle.
- Back-pressure: during a burst from requester 1, force wfull=1 for 3 cycles after the 2nd word:
  - winc=0 and ack=0 for those 3 cycles.
  - Words 3 and 4 are written after wfull drops, in order, with no duplicates.
- Withdrawal and end-to-end run:
  - Requester 3 drops req after 1 word → GRANT exits, next grant goes to requester 0.
  - End-to-end: connect to fifo_top, write 32 words from 2 requesters; the read side recovers each requester's sequence intact.
- Async reset mid-burst: assert wrst_n=0 between clock edges while winc=1 → winc, ack and busy go to 0 before the next edge; grant_id=0 after release.
